// File: rtl/xgxs_enc_8b10b_lanes.sv
// Multi-lane 8b/10b encoder for the XGXS PCS transmit path.
// Stage 1 registers the incoming word. Stage 2 encodes every lane from the
// running disparity and registers the symbols. RD chains lane 0 -> LANES-1
// and feeds back through rd_q, so the feedback loop stays inside stage 2.
// Symbol bit order is {j,h,g,f,i,e,d,c,b,a}; bit 0 (a) goes on the wire first.
module xgxs_enc_8b10b_lanes #(
    parameter int         LANES   = 4,
    parameter logic [9:0] BAD_SYM = 10'b1111110000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [8*LANES-1:0]    enc_data_in,
    input  logic [LANES-1:0]      konstant,
    input  logic [LANES-1:0]      bad_code,
    input  logic                  force_rd_en,
    input  logic                  force_rd_val,
    output logic                  out_valid,
    output logic [10*LANES-1:0]   enc_data_out,
    output logic                  rd_out,
    output logic [LANES-1:0]      k_err
);

    // ------------------------------------------------------------------
    // Code tables. 6b codes are written abcdei and 4b codes fghj, both
    // with the first-transmitted bit on the left, in their RD- form.
    // ------------------------------------------------------------------
    function automatic logic [5:0] tab6(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            5'd31:   c = 6'b101011;
            default: c = 6'b100111;
        endcase
        return c;
    endfunction

    // Data 3b/4b codes for RD- (y=7 is the primary P7 code).
    function automatic logic [3:0] tab4d(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            3'd7:    c = 4'b1110;
            default: c = 4'b1011;
        endcase
        return c;
    endfunction

    // K28.y 3b/4b codes for RD-; y = 1,2,5,6 are inverted w.r.t. data.
    function automatic logic [3:0] tabk4(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b0110;
            3'd2:    c = 4'b1010;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b0101;
            3'd6:    c = 4'b1001;
            3'd7:    c = 4'b0111;
            default: c = 4'b1011;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] ones6(input logic [5:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} +
               {2'b00, v[3]} + {2'b00, v[4]} + {2'b00, v[5]};
    endfunction

    function automatic logic [2:0] ones4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Supported control characters: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
    function automatic logic k_legal(input logic [7:0] b);
        logic [4:0] x;
        logic [2:0] y;
        x = b[4:0];
        y = b[7:5];
        return (x == 5'd28) ||
               ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                                (x == 5'd29) || (x == 5'd30)));
    endfunction

    // Encode one byte from rd_in; returns {rd_end, j,h,g,f,i,e,d,c,b,a}.
    // An unsupported K byte is encoded as the equivalent D character.
    function automatic logic [10:0] enc_sym(input logic [7:0] b,
                                            input logic       is_k,
                                            input logic       rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic       k_ok;
        logic       k28;
        logic [5:0] c6_raw;
        logic [5:0] c6;
        logic       rd_mid;
        logic       alt7;
        logic [3:0] c4_raw;
        logic [3:0] c4;
        logic       rd_end;
        x      = b[4:0];
        y      = b[7:5];
        k_ok   = is_k & k_legal(b);
        k28    = k_ok & (x == 5'd28);
        c6_raw = k28 ? 6'b001111 : tab6(x);
        // Unbalanced codes and the alternating D.7 code invert at RD+.
        c6     = (rd_in && ((ones6(c6_raw) != 3'd3) || ((x == 5'd7) && !k28)))
                 ? ~c6_raw : c6_raw;
        rd_mid = (ones6(c6) == 3'd3) ? rd_in : ~rd_in;
        // Alternate 7 avoids a run of five; every legal K.x.7 uses it.
        alt7   = (y == 3'd7) &&
                 (k_ok ||
                  (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                  ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
        c4_raw = k28 ? tabk4(y) : (alt7 ? 4'b0111 : tab4d(y));
        // K codes and D.x.3 alternate with RD even when balanced.
        c4     = (rd_mid && ((ones4(c4_raw) != 3'd2) || (y == 3'd3) || k28))
                 ? ~c4_raw : c4_raw;
        rd_end = (ones4(c4) == 3'd2) ? rd_mid : ~rd_mid;
        return {rd_end, c4[0], c4[1], c4[2], c4[3],
                c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
    endfunction

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    logic                 s1_valid_q;
    logic [8*LANES-1:0]   s1_data_q;
    logic [LANES-1:0]     s1_k_q;
    logic [LANES-1:0]     s1_bad_q;
    logic                 s1_force_en_q;
    logic                 s1_force_val_q;

    // Capture the incoming word and its per-lane qualifiers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_data_q      <= '0;
            s1_k_q         <= '0;
            s1_bad_q       <= '0;
            s1_force_en_q  <= 1'b0;
            s1_force_val_q <= 1'b0;
        end else begin
            s1_valid_q     <= in_valid;
            s1_data_q      <= enc_data_in;
            s1_k_q         <= konstant;
            s1_bad_q       <= bad_code;
            s1_force_en_q  <= force_rd_en;
            s1_force_val_q <= force_rd_val;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2
    // ------------------------------------------------------------------
    logic                 out_valid_q;
    logic [10*LANES-1:0]  enc_data_q;
    logic [10*LANES-1:0]  enc_data_d;
    logic [LANES-1:0]     k_err_q;
    logic [LANES-1:0]     k_err_d;
    logic                 rd_q;
    logic                 rd_d;

    // Encode all lanes, chaining RD from lane 0 upward; bad lanes pass RD through.
    always_comb begin : enc_chain
        logic        rd_run;
        logic [10:0] sym;
        enc_data_d = '0;
        k_err_d    = '0;
        sym        = 11'd0;
        rd_run     = s1_force_en_q ? s1_force_val_q : rd_q;
        for (int i = 0; i < LANES; i++) begin
            sym = enc_sym(s1_data_q[8*i +: 8], s1_k_q[i], rd_run);
            if (s1_bad_q[i]) begin
                enc_data_d[10*i +: 10] = BAD_SYM;
                k_err_d[i]             = 1'b0;
            end else begin
                enc_data_d[10*i +: 10] = sym[9:0];
                k_err_d[i]             = s1_k_q[i] & ~k_legal(s1_data_q[8*i +: 8]);
                rd_run                 = sym[10];
            end
        end
        rd_d = rd_run;
    end

    // Register encoded symbols and RD only for valid words; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            enc_data_q  <= '0;
            k_err_q     <= '0;
            rd_q        <= 1'b0;
        end else if (s1_valid_q) begin
            out_valid_q <= 1'b1;
            enc_data_q  <= enc_data_d;
            k_err_q     <= k_err_d;
            rd_q        <= rd_d;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign enc_data_out = enc_data_q;
    assign k_err        = k_err_q;
    assign rd_out       = rd_q;

endmodule

// File: tb/tb_xgxs_enc_8b10b_lanes.sv
// Directed bench for xgxs_enc_8b10b_lanes with LANES=4. Expected symbols
// are hand-derived from the standard 8b/10b tables in {j,h,g,f,i,e,d,c,b,a}
// order. Inputs are driven and outputs sampled on the falling edge.
module tb_xgxs_enc_8b10b_lanes;

    localparam int LANES = 4;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic [8*LANES-1:0]   enc_data_in;
    logic [LANES-1:0]     konstant;
    logic [LANES-1:0]     bad_code;
    logic                 force_rd_en;
    logic                 force_rd_val;
    logic                 out_valid;
    logic [10*LANES-1:0]  enc_data_out;
    logic                 rd_out;
    logic [LANES-1:0]     k_err;

    int checks_cnt;
    int errors_cnt;

    xgxs_enc_8b10b_lanes #(
        .LANES   (LANES),
        .BAD_SYM (10'b1111110000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .enc_data_in  (enc_data_in),
        .konstant     (konstant),
        .bad_code     (bad_code),
        .force_rd_en  (force_rd_en),
        .force_rd_val (force_rd_val),
        .out_valid    (out_valid),
        .enc_data_out (enc_data_out),
        .rd_out       (rd_out),
        .k_err        (k_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k,
                         input logic [3:0] bad, input logic fen, input logic fval);
        in_valid     = v;
        enc_data_in  = d;
        konstant     = k;
        bad_code     = bad;
        force_rd_en  = fen;
        force_rd_val = fval;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    // Drive one valid word, then idle; returns when its output is visible.
    task automatic run_word(input logic [31:0] d, input logic [3:0] k,
                            input logic [3:0] bad, input logic fen, input logic fval);
        drive(1'b1, d, k, bad, fen, fval);
        @(negedge clk);
        idle();
        @(negedge clk);
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", enc_data_out, 40'h0);
        check("rst_kerr", k_err, 4'h0);
        check("rst_rd", rd_out, 1'b0);

        // 4x K28.5 from RD-, with latency check
        rst = 1'b0;
        drive(1'b1, {4{8'hBC}}, 4'hF, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        check("k285_lat1", out_valid, 1'b0);
        @(negedge clk);
        check("k285_valid", out_valid, 1'b1);
        check("k285_data", enc_data_out, {10'h283, 10'h17C, 10'h283, 10'h17C});
        check("k285_rd", rd_out, 1'b0);
        check("k285_kerr", k_err, 4'h0);

        // Back-to-back D0.0 then D21.5
        drive(1'b1, {4{8'h00}}, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, {4{8'hB5}}, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        check("d00_data", enc_data_out, {4{10'h0B9}});
        check("d00_rd", rd_out, 1'b0);
        @(negedge clk);
        check("d215_valid", out_valid, 1'b1);
        check("d215_data", enc_data_out, {4{10'h155}});
        check("d215_rd", rd_out, 1'b0);

        // Force RD+ on 4x K28.5, then unforced D0.0 continues from RD+
        run_word({4{8'hBC}}, 4'hF, 4'h0, 1'b1, 1'b1);
        check("frc_data", enc_data_out, {10'h17C, 10'h283, 10'h17C, 10'h283});
        check("frc_rd", rd_out, 1'b1);
        run_word({4{8'h00}}, 4'h0, 4'h0, 1'b0, 1'b0);
        check("frc_next_data", enc_data_out, {4{10'h346}});
        check("frc_next_rd", rd_out, 1'b1);

        // Bad code on lane 1, forced RD-; lane 1 passes RD+ to lane 2
        run_word({4{8'hBC}}, 4'hF, 4'b0010, 1'b1, 1'b0);
        check("bad_data", enc_data_out, {10'h17C, 10'h283, 10'h3F0, 10'h17C});
        check("bad_rd", rd_out, 1'b1);
        check("bad_kerr", k_err, 4'h0);

        // Illegal K (K0.0) on lane 2 encodes as D0.0 and flags k_err
        run_word({8'h00, 8'h00, 8'h00, 8'hBC}, 4'b0101, 4'h0, 1'b1, 1'b0);
        check("kill_data", enc_data_out, {10'h346, 10'h346, 10'h346, 10'h17C});
        check("kill_kerr", k_err, 4'b0100);
        check("kill_rd", rd_out, 1'b1);

        // Legal K.x.7 characters from RD-
        run_word({8'hFE, 8'hFD, 8'hFB, 8'hF7}, 4'hF, 4'h0, 1'b1, 1'b0);
        check("kx7_data", enc_data_out, {10'h05E, 10'h05D, 10'h05B, 10'h057});
        check("kx7_kerr", k_err, 4'h0);
        check("kx7_rd", rd_out, 1'b0);

        // D.x.7 primary/alternate selection
        run_word({8'hEB, 8'hE0, 8'hEB, 8'hF1}, 4'h0, 4'h0, 1'b1, 1'b0);
        check("dx7_data", enc_data_out, {10'h1CB, 10'h239, 10'h04B, 10'h3B1});
        check("dx7_rd", rd_out, 1'b1);

        // Word in flight is discarded by reset; lane 0 restarts at RD-
        drive(1'b1, {4{8'h00}}, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        check("flush_valid", out_valid, 1'b0);
        check("flush_data", enc_data_out, 40'h0);
        check("flush_rd", rd_out, 1'b0);
        rst = 1'b0;
        drive(1'b1, {4{8'h00}}, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        check("flush_gap", out_valid, 1'b0);
        @(negedge clk);
        check("post_rst_data", enc_data_out, {4{10'h0B9}});
        check("post_rst_rd", rd_out, 1'b0);

        // Invalid word: outputs hold, force ignored, RD unchanged
        drive(1'b0, {4{8'hBC}}, 4'hF, 4'h0, 1'b1, 1'b1);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("gap_valid", out_valid, 1'b0);
        check("gap_hold", enc_data_out, {4{10'h0B9}});
        check("gap_rd", rd_out, 1'b0);
        run_word({4{8'hBC}}, 4'hF, 4'h0, 1'b0, 1'b0);
        check("gap_next_data", enc_data_out, {10'h283, 10'h17C, 10'h283, 10'h17C});
        check("gap_next_rd", rd_out, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
